// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 5-stage MIPS core.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction on a redirect instead of flushing it.
module fetch_stage #(
  parameter int                       N_BITS_PC    = 32,
  parameter int                       N_BITS_INSTR = 32,
  parameter int                       N_BITS_REG   = 5,
  parameter logic [N_BITS_INSTR-1:0]  HALT_WORD    = {N_BITS_INSTR{1'b1}}
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic                    i_stall,
  input  logic                    i_redirect,
  input  logic [N_BITS_PC-1:0]    i_redirect_pc,
  output logic [N_BITS_PC-1:0]    o_imem_addr,
  input  logic [N_BITS_INSTR-1:0] i_imem_data,
  output logic [N_BITS_PC-1:0]    o_pc,
  output logic [N_BITS_INSTR-1:0] o_instr_ifid,
  output logic [N_BITS_PC-1:0]    o_pc4_ifid,
  output logic [N_BITS_REG-1:0]   o_rs_ifid,
  output logic [N_BITS_REG-1:0]   o_rt_ifid,
  output logic                    o_valid_ifid,
  output logic                    o_halt
);

  localparam logic [N_BITS_PC-1:0] PC_STEP = N_BITS_PC'(4);

  logic [N_BITS_PC-1:0]    pc_q, pc_d;
  logic [N_BITS_INSTR-1:0] instr_q, instr_d;
  logic [N_BITS_PC-1:0]    pc4_q, pc4_d;
  logic                    valid_q, valid_d;
  logic                    halt_q, halt_d;
  logic [N_BITS_PC-1:0]    pc_plus4;
  logic                    fetched_halt;

  // Targets are word aligned; the two low bits of the redirect address are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  assign pc_plus4     = pc_q + PC_STEP;
  assign fetched_halt = (i_imem_data == HALT_WORD);

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    if (i_enable && !halt_q) begin
      if (i_redirect) begin
        pc_d = {i_redirect_pc[N_BITS_PC-1:2], 2'b00};
`ifdef BRANCH_DELAY_SLOT_EN
        instr_d = i_imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        halt_d  = fetched_halt;
`else
        instr_d = '0;
        pc4_d   = '0;
        valid_d = 1'b0;
`endif
      end else if (!i_stall) begin
        pc_d    = pc_plus4;
        instr_d = i_imem_data;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
        halt_d  = fetched_halt;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign o_imem_addr  = pc_q;
  assign o_pc         = pc_q;
  assign o_instr_ifid = instr_q;
  assign o_pc4_ifid   = pc4_q;
  assign o_rs_ifid    = instr_q[25:21];
  assign o_rt_ifid    = instr_q[20:16];
  assign o_valid_ifid = valid_q;
  assign o_halt       = halt_q;

endmodule
